// File: rtl/core_host_pkg.sv
// Shared types and widths for the core host sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_host_pkg;

  localparam int OP_W    = 4;   // opcode / mode width
  localparam int IN_W    = 8;   // input byte width
  localparam int OUT_W   = 14;  // core output / golden word width
  localparam int IN_AW   = 11;  // input memory address width
  localparam int OP_AW   = 10;  // opcode memory address width
  localparam int GOLD_AW = 12;  // golden memory address width
  localparam int OPC_W   = 11;  // opcode count width (1..OP_DEPTH)
  localparam int ERR_W   = 16;  // mismatch counter width
  localparam int OCNT_W  = 13;  // received-output counter width

  localparam logic [OP_W-1:0] OP_LOAD = 4'h0;

  // DRAIN is kept in the encoding for future use; nothing enters it today.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  // Saturating add of a small increment (0..3) to the error counter.
  function automatic logic [ERR_W-1:0] sat_add_err(input logic [ERR_W-1:0] a,
                                                   input logic [1:0] inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, a} + {{(ERR_W-1){1'b0}}, inc};
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/host_out_checker.sv
// Compares each core output with the golden stream and keeps mismatch/output counts.
// Latency: counters update on the edge that samples out_valid; golden address is registered.
// Backpressure: none, every out_valid cycle is consumed; past the golden end every output is an error.
module host_out_checker
  import core_host_pkg::*;
#(
  parameter int GOLD_DEPTH = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               out_valid,
  input  logic [OUT_W-1:0]   out_data,
  input  logic [OUT_W-1:0]   gold_rdata,
  input  logic               extra_err,
  output logic [GOLD_AW-1:0] gold_addr,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [OCNT_W-1:0]  out_cnt
);

  localparam int IDX_W = GOLD_AW + 1;
  localparam logic [IDX_W-1:0] GOLD_END = IDX_W'(GOLD_DEPTH);

  logic [IDX_W-1:0] gold_idx;
  logic             hit;
  logic             past_end;
  logic             mismatch;
  logic [1:0]       err_inc;

  assign hit       = en && out_valid;
  assign past_end  = (gold_idx == GOLD_END);
  assign mismatch  = past_end || (out_data != gold_rdata);
  // Watchdog expiry and a data mismatch can land on the same edge; count both.
  assign err_inc   = {1'b0, hit && mismatch} + {1'b0, extra_err};
  assign gold_addr = gold_idx[GOLD_AW-1:0];

  // Golden index and counters; a new sequence clears them.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      gold_idx <= '0;
      err_cnt  <= '0;
      out_cnt  <= '0;
    end else begin
      if (hit) begin
        if (!past_end) gold_idx <= gold_idx + IDX_W'(1);
        out_cnt <= out_cnt + OCNT_W'(1);
      end
      err_cnt <= sat_add_err(err_cnt, err_inc);
    end
  end

endmodule

// File: rtl/core_host_seq.sv
// Host sequencer: issues opcodes and load bytes to the core, checks its outputs against golden data.
// Latency: op_ready sampled at edge N gives a one-cycle op_valid in cycle N+1; loads stream one byte/cycle.
// Backpressure: holds op issue until op_ready, holds byte/address while in_ready=0; HOST_TIMEOUT_EN adds a stall watchdog.
module core_host_seq
  import core_host_pkg::*;
#(
  parameter int IN_DEPTH   = 2048,
  parameter int OP_DEPTH   = 1024,
  parameter int GOLD_DEPTH = 4096,
  parameter int TIMEOUT    = 65535
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [OPC_W-1:0]   i_op_count,
  output logic [OP_AW-1:0]   o_op_addr,
  input  logic [OP_W-1:0]    i_op_rdata,
  output logic [IN_AW-1:0]   o_in_addr,
  input  logic [IN_W-1:0]    i_in_rdata,
  output logic [GOLD_AW-1:0] o_gold_addr,
  input  logic [OUT_W-1:0]   i_gold_rdata,
  output logic               o_op_valid,
  output logic [OP_W-1:0]    o_op_mode,
  input  logic               i_op_ready,
  output logic               o_in_valid,
  output logic [IN_W-1:0]    o_in_data,
  input  logic               i_in_ready,
  input  logic               i_out_valid,
  input  logic [OUT_W-1:0]   i_out_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [ERR_W-1:0]   o_err_cnt,
  output logic [OCNT_W-1:0]  o_out_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [OPC_W-1:0]   op_idx;
  logic [IN_AW-1:0]   in_idx;
  logic               start_ok;
  logic               accept;
  logic               last_byte;
  logic               all_issued;
  logic               tmo;

  assign start_ok   = i_start && ((state == IDLE) || (state == DONE));
  assign accept     = (state == LOAD) && i_in_ready;
  assign last_byte  = (in_idx == IN_AW'(IN_DEPTH - 1));
  // Also stop at the memory depth so an oversized count cannot run off the end.
  assign all_issued = (op_idx == i_op_count) || (op_idx == OPC_W'(OP_DEPTH));
  assign o_op_addr  = op_idx[OP_AW-1:0];
  assign o_in_addr  = in_idx;
  assign o_busy     = (state != IDLE) && (state != DONE);
  assign o_done     = (state == DONE);

`ifdef HOST_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        stall;

  assign stall = ((state == WAIT_RDY) && !i_op_ready) || ((state == LOAD) && !i_in_ready);
  assign tmo   = stall && (wd_cnt == 16'(TIMEOUT - 1));

  // Watchdog: consecutive cycles without handshake progress.
  always_ff @(posedge i_clk) begin
    if (i_rst || !stall) wd_cnt <= '0;
    else                 wd_cnt <= wd_cnt + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and core-facing outputs, all decoded from registered state.
  always_comb begin
    state_nxt  = state;
    o_op_valid = 1'b0;
    o_op_mode  = '0;
    o_in_valid = 1'b0;
    o_in_data  = '0;
    case (state)
      IDLE, DONE: begin
        if (i_start) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        // The op_ready that follows the last op marks its completion.
        if (i_op_ready) state_nxt = all_issued ? DONE : ISSUE;
      end
      ISSUE: begin
        o_op_valid = 1'b1;
        o_op_mode  = i_op_rdata;
        state_nxt  = (i_op_rdata == OP_LOAD) ? LOAD : WAIT_RDY;
      end
      LOAD: begin
        o_in_valid = 1'b1;
        o_in_data  = i_in_rdata;
        if (accept && last_byte) state_nxt = WAIT_RDY;
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (tmo) state_nxt = DONE;
  end

  // Opcode and input byte address counters.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      op_idx <= '0;
      in_idx <= '0;
    end else begin
      if (state == ISSUE) op_idx <= op_idx + OPC_W'(1);
      if (accept)         in_idx <= last_byte ? '0 : in_idx + IN_AW'(1);
    end
  end

  host_out_checker #(
    .GOLD_DEPTH (GOLD_DEPTH)
  ) u_checker (
    .clk        (i_clk),
    .rst        (i_rst),
    .clr        (start_ok),
    .en         (state != IDLE),
    .out_valid  (i_out_valid),
    .out_data   (i_out_data),
    .gold_rdata (i_gold_rdata),
    .extra_err  (tmo),
    .gold_addr  (o_gold_addr),
    .err_cnt    (o_err_cnt),
    .out_cnt    (o_out_cnt)
  );

endmodule

// File: tb/tb_core_host_seq.sv
// Testbench for core_host_seq: pattern memories, a core-side behavioural model and a scoreboard.
// Latency: inputs are driven 1ns after each rising edge and outputs sampled at the same point.
// Backpressure: the core model drives op_ready/in_ready either by a fixed policy or at random.
`timescale 1ns/1ps
module tb_core_host_seq;

  localparam int IN_DEPTH   = 2048;
  localparam int OP_DEPTH   = 1024;
  localparam int GOLD_DEPTH = 4096;
  localparam int TIMEOUT    = 16;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start;
  logic [10:0] i_op_count;
  logic [9:0]  o_op_addr;
  logic [3:0]  i_op_rdata;
  logic [10:0] o_in_addr;
  logic [7:0]  i_in_rdata;
  logic [11:0] o_gold_addr;
  logic [13:0] i_gold_rdata;
  logic        o_op_valid;
  logic [3:0]  o_op_mode;
  logic        i_op_ready;
  logic        o_in_valid;
  logic [7:0]  o_in_data;
  logic        i_in_ready;
  logic        i_out_valid;
  logic [13:0] i_out_data;
  logic        o_busy, o_done;
  logic [15:0] o_err_cnt;
  logic [12:0] o_out_cnt;

  logic [3:0]  op_mem   [0:OP_DEPTH-1];
  logic [7:0]  in_mem   [0:IN_DEPTH-1];
  logic [13:0] gold_mem [0:GOLD_DEPTH-1];

  assign i_op_rdata   = op_mem[o_op_addr];
  assign i_in_rdata   = in_mem[o_in_addr];
  assign i_gold_rdata = gold_mem[o_gold_addr];

  always #5 i_clk = ~i_clk;

  core_host_seq #(
    .IN_DEPTH(IN_DEPTH), .OP_DEPTH(OP_DEPTH), .GOLD_DEPTH(GOLD_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op_count(i_op_count),
    .o_op_addr(o_op_addr), .i_op_rdata(i_op_rdata), .o_in_addr(o_in_addr),
    .i_in_rdata(i_in_rdata), .o_gold_addr(o_gold_addr), .i_gold_rdata(i_gold_rdata),
    .o_op_valid(o_op_valid), .o_op_mode(o_op_mode), .i_op_ready(i_op_ready),
    .o_in_valid(o_in_valid), .o_in_data(o_in_data), .i_in_ready(i_in_ready),
    .i_out_valid(i_out_valid), .i_out_data(i_out_data), .o_busy(o_busy),
    .o_done(o_done), .o_err_cnt(o_err_cnt), .o_out_cnt(o_out_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol-level view of the sequence as seen from the core side.
  int  m_n, m_issued, m_in_ptr, m_load_cnt, m_lcyc, m_out_k, m_exp_err, m_exp_out;
  bit  m_busy, m_done, m_issue, m_load, seen_done, start_req;
  // Core model policy.
  bit  rnd_mode, bp_toggle;
  int  p_op, p_in, p_out, p_bad, outs_per_op, corrupt_k, pending;
  // Activity seen during the current sequence.
  int  act_issues, act_accepts, act_load_cyc;

  task automatic model_reset();
    m_issued = 0; m_in_ptr = 0; m_load_cnt = 0; m_lcyc = 0; m_out_k = 0;
    m_exp_err = 0; m_exp_out = 0; m_busy = 0; m_done = 0; m_issue = 0; m_load = 0;
    pending = 0; start_req = 0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One cycle: check the DUT against the model, drive the core side, advance the model.
  task automatic step();
    bit rdy_op, rdy_in, ov, bad, st_ok;
    logic [13:0] od;
    tick();
    seen_done = m_done;
    chk("op_valid", o_op_valid, m_issue);
    chk("in_valid", o_in_valid, m_load);
    chk("busy", o_busy, m_busy);
    chk("done", o_done, m_done);
    chk("err_cnt", o_err_cnt, m_exp_err);
    chk("out_cnt", o_out_cnt, m_exp_out % 8192);
    if (m_issue) begin
      chk("op_addr", o_op_addr, m_issued);
      chk("op_mode", o_op_mode, op_mem[m_issued]);
    end
    if (m_load) begin
      chk("in_addr", o_in_addr, m_in_ptr);
      chk("in_data", o_in_data, in_mem[m_in_ptr]);
    end
    if (o_op_valid) act_issues++;
    if (o_in_valid) act_load_cyc++;

    if (rnd_mode && m_busy && $urandom_range(63) == 0) start_req = 1;
    if (rnd_mode) begin
      rdy_op = $urandom_range(99) < p_op;
      rdy_in = $urandom_range(99) < p_in;
      ov     = (m_busy || m_done) && !start_req && ($urandom_range(99) < p_out);
    end else begin
      rdy_op = !m_load && !m_issue && (pending == 0);
      rdy_in = bp_toggle ? (m_lcyc % 2 == 1) : 1'b1;
      ov     = (pending > 0) && (m_busy || m_done) && !start_req;
    end
    bad = ov && (rnd_mode ? ($urandom_range(99) < p_bad) : (m_out_k == corrupt_k));
    od  = gold_mem[m_out_k % GOLD_DEPTH];
    if (bad) od = od ^ 14'h0005;
    i_op_ready  = rdy_op;
    i_in_ready  = rdy_in;
    i_out_valid = ov;
    i_out_data  = ov ? od : 14'($urandom);
    i_start     = start_req;
    if (o_in_valid && rdy_in) act_accepts++;

    if (ov) begin
      m_exp_out++;
      if (bad || m_out_k >= GOLD_DEPTH) m_exp_err = (m_exp_err < 65535) ? m_exp_err + 1 : 65535;
      m_out_k++;
      if (!rnd_mode && pending > 0) pending--;
    end
    st_ok = start_req && !m_busy;
    if (st_ok) begin
      model_reset();
      m_busy = 1;
    end else if (m_issue) begin
      m_load     = (op_mem[m_issued] == 4'h0);
      m_lcyc     = 0;
      m_load_cnt = 0;
      if (!m_load && !rnd_mode) pending = outs_per_op;
      m_issued++;
      m_issue = 0;
    end else if (m_load) begin
      m_lcyc++;
      if (rdy_in) begin
        m_in_ptr = (m_in_ptr + 1) % IN_DEPTH;
        m_load_cnt++;
        if (m_load_cnt == IN_DEPTH) m_load = 0;
      end
    end else if (m_busy && rdy_op) begin
      if (m_issued == m_n) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_issue = 1;
      end
    end
    start_req = 0;
  endtask

  // Start a sequence of n ops and run until o_done is observed (or abort after abort_at bytes).
  task automatic run_seq(input int n, input int budget, input int abort_at, output bit ok);
    ok = 0;
    i_op_count = 11'(n);
    m_n = n;
    act_issues = 0; act_accepts = 0; act_load_cyc = 0;
    start_req = 1;
    step();
    for (int c = 0; c < budget; c++) begin
      step();
      if (abort_at > 0 && act_accepts >= abort_at) return;
      if (seen_done) begin
        ok = 1;
        return;
      end
    end
    chk("seq_complete", o_done, 1);
  endtask

  typedef struct {
    int          n;
    logic [15:0] ops;      // op k in nibble k
    bit          bp;
    int          outs;
    int          corrupt;
    int          e_issues, e_accepts, e_lcyc, e_out, e_err;
  } vec_t;

  vec_t vecs[5];
  bit   ok;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    // n, ops, bp, outs/op, corrupt, issues, accepts, load cycles, outputs, errors
    vecs[0] = '{1, 16'h0000, 1'b0, 0, -1, 1, 2048, 2048, 0, 0};     // single load
    vecs[1] = '{1, 16'h0000, 1'b1, 0, -1, 1, 2048, 4096, 0, 0};     // in_ready toggling
    vecs[2] = '{4, 16'h2950, 1'b0, 3, -1, 4, 2048, 2048, 9, 0};     // ops 0,5,9,2
    vecs[3] = '{4, 16'h2950, 1'b0, 3,  2, 4, 2048, 2048, 9, 1};     // golden[2] corrupted
    vecs[4] = '{1, 16'h0001, 1'b0, 4097, -1, 1, 0, 0, 4097, 1};     // one output past golden end

    for (int k = 0; k < OP_DEPTH; k++)   op_mem[k]   = 4'($urandom_range(1, 15));
    for (int k = 0; k < IN_DEPTH; k++)   in_mem[k]   = 8'($urandom);
    for (int k = 0; k < GOLD_DEPTH; k++) gold_mem[k] = 14'($urandom);

    i_rst = 1; i_start = 0; i_op_count = 0;
    i_op_ready = 0; i_in_ready = 0; i_out_valid = 0; i_out_data = 0;
    model_reset();
    rnd_mode = 0; bp_toggle = 0; outs_per_op = 0; corrupt_k = -1;
    p_op = 0; p_in = 0; p_out = 0; p_bad = 0;
    tick();
    tick();
    chk("rst_op_valid", o_op_valid, 0);
    chk("rst_in_valid", o_in_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_out_cnt", o_out_cnt, 0);
    chk("rst_in_addr", o_in_addr, 0);
    chk("rst_gold_addr", o_gold_addr, 0);
    i_rst = 0;

    // Directed table.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) op_mem[k] = vecs[r].ops[4*k +: 4];
      rnd_mode = 0; bp_toggle = vecs[r].bp;
      outs_per_op = vecs[r].outs; corrupt_k = vecs[r].corrupt;
      run_seq(vecs[r].n, 12000, 0, ok);
      chk($sformatf("row%0d_issues", r), act_issues, vecs[r].e_issues);
      chk($sformatf("row%0d_accepts", r), act_accepts, vecs[r].e_accepts);
      chk($sformatf("row%0d_load_cycles", r), act_load_cyc, vecs[r].e_lcyc);
      chk($sformatf("row%0d_out_cnt", r), o_out_cnt, vecs[r].e_out);
      chk($sformatf("row%0d_err_cnt", r), o_err_cnt, vecs[r].e_err);
    end

    // Reset in the middle of a load, then a clean restart from byte 0.
    op_mem[0] = 4'h0; rnd_mode = 0; bp_toggle = 0; outs_per_op = 0; corrupt_k = -1;
    run_seq(1, 5000, 100, ok);
    chk("abort_accepts", act_accepts, 100);
    i_rst = 1;
    tick();
    chk("abort_op_valid", o_op_valid, 0);
    chk("abort_op_mode", o_op_mode, 0);
    chk("abort_in_valid", o_in_valid, 0);
    chk("abort_in_data", o_in_data, 0);
    chk("abort_in_addr", o_in_addr, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_err_cnt", o_err_cnt, 0);
    chk("abort_out_cnt", o_out_cnt, 0);
    i_rst = 0;
    model_reset();
    run_seq(1, 5000, 0, ok);
    chk("restart_accepts", act_accepts, IN_DEPTH);

    // Random traffic against the model, at most one load per sequence.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 6);
      for (int k = 0; k < n; k++) op_mem[k] = (k == 0 && r != 1) ? 4'h0 : 4'($urandom_range(1, 15));
      rnd_mode = 1; p_op = 50; p_in = 60; p_out = 30; p_bad = 10;
      run_seq(n, 15000, 0, ok);
      chk($sformatf("rnd%0d_issues", r), act_issues, n);
      for (int c = 0; c < 20; c++) step();   // outputs still counted while done is held
    end

    // Core never raises op_ready.
    rnd_mode = 0;
    i_op_ready = 0; i_in_ready = 0; i_out_valid = 0; i_op_count = 11'd1;
    i_start = 1;
    tick();
    i_start = 0;
    chk("stuck_busy", o_busy, 1);
`ifdef HOST_TIMEOUT_EN
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      tick();
      chk("wd_not_yet_done", o_done, 0);
    end
    tick();
    chk("wd_done", o_done, 1);
    chk("wd_err_cnt", o_err_cnt, 1);
`else
    for (int c = 0; c < 40; c++) tick();
    chk("stuck_still_busy", o_busy, 1);
    chk("stuck_not_done", o_done, 0);
`endif
    i_rst = 1;
    tick();
    i_rst = 0;
    chk("final_rst_busy", o_busy, 0);
    model_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_host_seq.md
# core_host_seq

Synthesizable host sequencer that drives the image-processing `core` from the initiator side of its op/in/out handshakes. It reads opcodes and input bytes from external pattern memories, issues them to the core under the op_ready/in_ready protocol, and checks every core output against a golden memory. It replaces hand-written stimulus for FPGA/emulation runs and is the sequencer half of the core's self-test harness.

## Interface
- IN_DEPTH, 2048: bytes streamed per load op
- OP_DEPTH, 1024: opcode memory depth
- GOLD_DEPTH, 4096: golden memory depth
- TIMEOUT, 65535: watchdog limit in cycles (used only with HOST_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse
- i_op_count  in  11  number of opcodes to issue (1..OP_DEPTH)
- o_op_addr  out  10  opcode memory address
- i_op_rdata  in  4  opcode memory data (combinational read)
- o_in_addr  out  11  input memory address
- i_in_rdata  in  8  input memory data (combinational read)
- o_gold_addr  out  12  golden memory address
- i_gold_rdata  in  14  golden memory data (combinational read)
- o_op_valid  out  1  to core
- o_op_mode  out  4  to core
- i_op_ready  in  1  from core
- o_in_valid  out  1  to core
- o_in_data  out  8  to core
- i_in_ready  in  1  from core
- i_out_valid  in  1  from core
- i_out_data  in  14  from core
- o_busy  out  1  sequence running
- o_done  out  1  sequence finished, held until next i_start
- o_err_cnt  out  16  mismatch count, saturating at 16'hFFFF
- o_out_cnt  out  13  outputs received

## Operation
- States: IDLE, WAIT_RDY, ISSUE, LOAD, DRAIN, DONE.
- IDLE/DONE: i_start clears op_idx, in_idx, gold_idx, o_err_cnt, o_out_cnt and o_done, then enters WAIT_RDY. i_start is ignored in all other states.
- WAIT_RDY: wait for i_op_ready=1.
  - On that cycle, if op_idx==i_op_count, go DONE; the core's final op_ready marks completion of the last op.
  - Otherwise go ISSUE.
- ISSUE: exactly one cycle with o_op_valid=1 and o_op_mode=i_op_rdata at o_op_addr=op_idx; op_idx increments.
  - Mode 4'h0 (OP_LOAD) goes to LOAD.
  - Any other mode goes to WAIT_RDY.
- LOAD:
  - o_in_valid=1 and o_in_data=i_in_rdata at o_in_addr=in_idx.
  - A byte is accepted when o_in_valid and i_in_ready are both 1; in_idx then increments.
  - After IN_DEPTH accepts: in_idx wraps to 0, o_in_valid drops on the next cycle, go WAIT_RDY.
  - When i_in_ready=0, data and address hold.
- Checker runs in every state except IDLE. On each i_out_valid=1 cycle:
  - compare i_out_data with i_gold_rdata at o_gold_addr=gold_idx; a mismatch increments o_err_cnt;
  - gold_idx and o_out_cnt increment.
  - If gold_idx==GOLD_DEPTH, every further output counts as an error and gold_idx holds.
- i_out_valid arriving in the same cycle as i_op_ready or an accept: both are processed.

## Timing
- Reset values: o_op_valid, o_op_mode, o_in_valid, o_in_data, o_busy, o_done = 0; o_err_cnt, o_out_cnt = 0; all addresses = 0; state = IDLE.
- Reset mid-sequence aborts immediately to the reset values.
- i_start at edge N puts the FSM in WAIT_RDY at N+1; o_busy=1 from N+1 until DONE is entered.
- i_op_ready sampled at edge N gives o_op_valid=1 during cycle N+1 only.
- LOAD streams one byte per cycle while i_in_ready=1, with no bubbles.
- o_done rises the cycle after the final i_op_ready is sampled.
- All core-facing outputs are registered or decoded from registered state; there are no combinational paths from core inputs to core outputs.

## Configuration
- HOST_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles spent in WAIT_RDY without i_op_ready, or in LOAD without i_in_ready.
  - It clears on any progress.
  - Reaching TIMEOUT forces DONE and adds 1 to o_err_cnt.
- Undefined: no watchdog; the FSM waits indefinitely.

## Structure
- Package core_host_pkg holds:
  - state enum;
  - OP_LOAD = 4'h0;
  - width constants: 4 (op), 8 (in), 14 (out), 11/10/12 (address widths).
- Sub-module host_out_checker holds gold_idx, the comparison, and the o_err_cnt/o_out_cnt counters. The top level holds the FSM and the op/in address counters.

## Test plan
- **Single load:** i_op_count=1, op mem[0]=0, core model ready → op_valid pulses once with mode 0; 2048 bytes accepted in order (in_data==mem[k]); o_done=1 after the next op_ready; err_cnt=0.
- **Backpressure:** in_ready toggles 1/0 every cycle during load → no byte duplicated or skipped; load spans 4096 cycles.
- **Mixed ops:** ops {0,5,9,2}, model emits 3 outputs per non-load op matching golden → o_out_cnt=9, o_err_cnt=0, op_valid asserted exactly 4 times.
- **Mismatch:** golden[2] corrupted → o_err_cnt=1. Output past GOLD_DEPTH → counted as an error.
- **Reset mid-load:** i_rst at byte 100 → all outputs 0 the next cycle. A fresh i_start restarts from byte 0.
- **Watchdog (HOST_TIMEOUT_EN, TIMEOUT=16):** op_ready never asserted → o_done=1 after 16 cycles in WAIT_RDY, o_err_cnt=1.
